// File: rtl/decode_stage.sv
// decode_stage: instruction-decode stage with an integrated register file
// and a single ID/EX pipeline register.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   if_valid/if_instr    instruction offered by fetch
//   if_ready             decode consumes if_instr this cycle (combinational)
//   wb_we/addr/data      register write-back port, bypassed into operand reads
//   flush                drop the ID/EX contents and the incoming instruction
//   ex_ready             execute accepts the ID/EX contents
//   ex_*                 decoded ID/EX payload, qualified by ex_valid
//   hazard_stalls        saturating count of load-use stall cycles
module decode_stage #(
  parameter int         XLEN        = 32,
  parameter int         REG_ADDR_W  = 5,
  parameter int         RTYPE_MAX   = 5,
  parameter logic [5:0] LOAD_OPCODE = 6'h23,
  parameter int         CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  output logic                  if_ready,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [5:0]            ex_opcode,
  output logic [XLEN-1:0]       ex_a,
  output logic [XLEN-1:0]       ex_b,
  output logic [XLEN-1:0]       ex_rt_data,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_is_r,
  output logic                  ex_is_load,
  output logic [CNT_W-1:0]      hazard_stalls
);

  localparam int         NREG         = 2**REG_ADDR_W;
  localparam logic [5:0] RTYPE_MAX_OP = 6'(RTYPE_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [XLEN-1:0]       rf_q [NREG];
  logic [XLEN-1:0]       rf_d [NREG];

  logic                  ex_valid_q,   ex_valid_d;
  logic [5:0]            ex_opcode_q,  ex_opcode_d;
  logic [XLEN-1:0]       ex_a_q,       ex_a_d;
  logic [XLEN-1:0]       ex_b_q,       ex_b_d;
  logic [XLEN-1:0]       ex_rt_data_q, ex_rt_data_d;
  logic [REG_ADDR_W-1:0] ex_dest_q,    ex_dest_d;
  logic                  ex_is_r_q,    ex_is_r_d;
  logic                  ex_is_load_q, ex_is_load_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;

  logic [5:0]            op;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic                  is_r, is_load, hazard, adv;
  logic [XLEN-1:0]       rs_val, rt_val, imm_ext;

  // Field extraction, operand read with write-back bypass, hazard check
  always_comb begin
    op      = if_instr[31:26];
    rs      = if_instr[21 +: REG_ADDR_W];
    rt      = if_instr[16 +: REG_ADDR_W];
    rd      = if_instr[11 +: REG_ADDR_W];
    is_r    = (op <= RTYPE_MAX_OP);
    is_load = (op == LOAD_OPCODE);
    imm_ext = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

    // r0 is hard-wired to zero, so it is never bypassed either
    if (rs == '0)                   rs_val = '0;
    else if (wb_we && wb_addr == rs) rs_val = wb_data;
    else                            rs_val = rf_q[rs];

    if (rt == '0)                   rt_val = '0;
    else if (wb_we && wb_addr == rt) rt_val = wb_data;
    else                            rt_val = rf_q[rt];

    hazard   = ex_valid_q && ex_is_load_q && (ex_dest_q != '0) &&
               ((ex_dest_q == rs) || (is_r && (ex_dest_q == rt)));
    adv      = !ex_valid_q || ex_ready;
    if_ready = flush || (adv && !hazard);
  end

  // Next-state for register file and ID/EX register
  always_comb begin
    rf_d = rf_q;
    if (wb_we && wb_addr != '0) rf_d[wb_addr] = wb_data;

    ex_valid_d   = ex_valid_q;
    ex_opcode_d  = ex_opcode_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_dest_d    = ex_dest_q;
    ex_is_r_d    = ex_is_r_q;
    ex_is_load_d = ex_is_load_q;
    cnt_d        = cnt_q;

    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (adv && hazard) begin
      // bubble: the dependent instruction waits one cycle on the input
      ex_valid_d = 1'b0;
      if (if_valid) cnt_d = sat_inc(cnt_q);
    end else if (adv) begin
      ex_valid_d = if_valid;
      if (if_valid) begin
        ex_opcode_d  = op;
        ex_a_d       = rs_val;
        ex_b_d       = is_r ? rt_val : imm_ext;
        ex_rt_data_d = rt_val;
        ex_dest_d    = is_r ? rd : rt;
        ex_is_r_d    = is_r;
        ex_is_load_d = is_load;
      end
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      ex_valid_q   <= 1'b0;
      ex_opcode_q  <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_rt_data_q <= '0;
      ex_dest_q    <= '0;
      ex_is_r_q    <= 1'b0;
      ex_is_load_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      rf_q         <= rf_d;
      ex_valid_q   <= ex_valid_d;
      ex_opcode_q  <= ex_opcode_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_dest_q    <= ex_dest_d;
      ex_is_r_q    <= ex_is_r_d;
      ex_is_load_q <= ex_is_load_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_opcode     = ex_opcode_q;
  assign ex_a          = ex_a_q;
  assign ex_b          = ex_b_q;
  assign ex_rt_data    = ex_rt_data_q;
  assign ex_dest       = ex_dest_q;
  assign ex_is_r       = ex_is_r_q;
  assign ex_is_load    = ex_is_load_q;
  assign hazard_stalls = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed test-plan sequences followed by randomized
// traffic, all checked every cycle against a behavioural model of the
// register file and the ID/EX slot.
module tb_decode_stage;

  localparam int CW = 2;
  localparam logic [5:0] LD = 6'h23;

  logic        clk = 1'b0;
  logic        reset, if_valid, if_ready, wb_we, flush, ex_ready;
  logic [31:0] if_instr, wb_data;
  logic [4:0]  wb_addr;
  logic        ex_valid, ex_is_r, ex_is_load;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_a, ex_b, ex_rt_data;
  logic [4:0]  ex_dest;
  logic [CW-1:0] hazard_stalls;

  decode_stage #(.XLEN(32), .REG_ADDR_W(5), .RTYPE_MAX(5), .LOAD_OPCODE(LD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rt_data(ex_rt_data), .ex_dest(ex_dest), .ex_is_r(ex_is_r), .ex_is_load(ex_is_load),
    .hazard_stalls(hazard_stalls)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] m_rf [32];
  logic        m_v, m_isr, m_isl, m_rst;
  logic [5:0]  m_op;
  logic [31:0] m_a, m_b, m_rt;
  logic [4:0]  m_dest;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] s, t, d);
    return {op, s, t, d, 11'b0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] rdv(input logic [4:0] i, input logic we, input logic [4:0] wa,
                                      input logic [31:0] wd);
    if (i == 0) return 32'd0;
    if (we && wa == i) return wd;
    return m_rf[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_v = 0; m_isr = 0; m_isl = 0; m_op = 0; m_a = 0; m_b = 0; m_rt = 0; m_dest = 0; m_cnt = 0;
    m_rst = 1;
  endtask

  // One clock cycle: drive, check if_ready, advance model, check ex_* after the edge
  task automatic cyc(input logic v, input logic [31:0] ins, input logic er, input logic fl,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic rs_t);
    logic [5:0] op;
    logic [4:0] s, t, d;
    logic isr, hz, adv;
    @(negedge clk);
    if_valid = v; if_instr = ins; ex_ready = er; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd; reset = rs_t;
    op = ins[31:26]; s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
    isr = (op <= 6'd5);
    hz  = m_v && m_isl && (m_dest != 0) && ((m_dest == s) || (isr && (m_dest == t)));
    adv = !m_v || er;
    #1 check("if_ready", if_ready, fl || (adv && !hz));
    if (rs_t) begin
      model_reset();
    end else begin
      m_rst = 0;
      if (v && hz && adv && !fl && m_cnt < 3) m_cnt++;
      if (fl) m_v = 0;
      else if (adv && hz) m_v = 0;
      else if (adv) begin
        m_v = v;
        if (v) begin
          m_op = op; m_isr = isr; m_isl = (op == LD);
          m_a  = rdv(s, we, wa, wd);
          m_rt = rdv(t, we, wa, wd);
          m_b  = isr ? m_rt : {{16{ins[15]}}, ins[15:0]};
          m_dest = isr ? d : t;
        end
      end
      if (we && wa != 0) m_rf[wa] = wd;
    end
    @(posedge clk);
    #1;
    check("ex_valid", ex_valid, m_v);
    check("hazard_stalls", hazard_stalls, m_cnt);
    if (m_v || m_rst) begin
      check("ex_opcode", ex_opcode, m_op);
      check("ex_a", ex_a, m_a);
      check("ex_b", ex_b, m_b);
      check("ex_rt_data", ex_rt_data, m_rt);
      check("ex_dest", ex_dest, m_dest);
      check("ex_is_r", ex_is_r, m_isr);
      check("ex_is_load", ex_is_load, m_isl);
    end
  endtask

  task automatic send(input logic [31:0] ins);
    cyc(1, ins, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    cyc(0, 32'd0, 1, 0, 1, a, d, 0);
  endtask

  initial begin
    reset = 1; if_valid = 0; if_instr = 0; ex_ready = 1; flush = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    repeat (2) @(posedge clk);

    // reset state
    cyc(0, 32'd0, 1, 0, 0, 0, 0, 1);
    check("reset_valid", ex_valid, 0);
    check("reset_cnt", hazard_stalls, 0);

    // R-type with bypass
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    wb(5'd4, 32'h1234);
    send(mk_r(6'd0, 5'd1, 5'd2, 5'd3));
    check("rtype_a", ex_a, 32'd5);
    check("rtype_b", ex_b, 32'd7);
    check("rtype_dest", ex_dest, 5'd3);
    check("rtype_is_r", ex_is_r, 1);
    cyc(1, mk_r(6'd0, 5'd1, 5'd2, 5'd3), 1, 0, 1, 5'd2, 32'd9, 0);
    check("bypass_b", ex_b, 32'd9);

    // sign extension
    send(mk_i(6'd8, 5'd1, 5'd4, 16'hFFFE));
    check("sext_b", ex_b, 32'hFFFFFFFE);
    check("sext_dest", ex_dest, 5'd4);
    check("sext_is_r", ex_is_r, 0);
    check("sext_rt_data", ex_rt_data, 32'h1234);

    // load-use: one bubble, then the dependent instruction
    send(mk_i(LD, 5'd1, 5'd6, 16'd0));
    send(mk_r(6'd0, 5'd6, 5'd2, 5'd7));
    check("lu_bubble", ex_valid, 0);
    send(mk_r(6'd0, 5'd6, 5'd2, 5'd7));
    check("lu_dep_valid", ex_valid, 1);
    check("lu_dep_dest", ex_dest, 5'd7);
    check("lu_cnt", hazard_stalls, 1);

    // dependency on r0 never stalls
    send(mk_i(LD, 5'd1, 5'd0, 16'd0));
    send(mk_r(6'd0, 5'd0, 5'd0, 5'd9));
    check("r0_no_stall", ex_valid, 1);
    check("r0_dest", ex_dest, 5'd9);

    // backpressure
    send(mk_r(6'd1, 5'd1, 5'd2, 5'd10));
    repeat (3) cyc(1, mk_r(6'd2, 5'd2, 5'd1, 5'd11), 0, 0, 0, 0, 0, 0);
    check("bp_hold_dest", ex_dest, 5'd10);
    check("bp_cnt", hazard_stalls, 1);
    send(mk_r(6'd2, 5'd2, 5'd1, 5'd11));
    check("bp_release_dest", ex_dest, 5'd11);

    // flush during stall
    send(mk_i(LD, 5'd1, 5'd6, 16'd0));
    cyc(1, mk_r(6'd0, 5'd6, 5'd2, 5'd7), 0, 1, 0, 0, 0, 0);
    check("flush_valid", ex_valid, 0);

    // saturation
    for (int i = 0; i < 5; i++) begin
      send(mk_i(LD, 5'd1, 5'd6, 16'd0));
      send(mk_r(6'd0, 5'd6, 5'd2, 5'd7));
      send(mk_r(6'd0, 5'd6, 5'd2, 5'd7));
    end
    check("sat_cnt", hazard_stalls, 3);

    // reset mid-stall
    send(mk_i(LD, 5'd1, 5'd6, 16'd0));
    cyc(1, mk_r(6'd0, 5'd6, 5'd2, 5'd7), 1, 0, 0, 0, 0, 1);
    check("rst_valid", ex_valid, 0);
    check("rst_cnt", hazard_stalls, 0);
    check("rst_a", ex_a, 0);
    send(mk_r(6'd0, 5'd1, 5'd2, 5'd3));
    check("rst_rf_a", ex_a, 0);
    check("rst_rf_b", ex_b, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op;
      logic [31:0] ins;
      op  = ($urandom_range(0, 3) == 0) ? LD : 6'($urandom_range(0, 12));
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      cyc(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
